dnn_accel_mult_pipe: RTL and testbench

Parametrised, pipelined integer multiplier for the DNN accelerator datapath and the Nios II custom-multiply path. Splits each WIDTH-bit operand into two half-width limbs, registers the partial products, then combines them into either the low or the high WIDTH bits of the 2·WIDTH-bit product. Supports signed, unsigned and mixed-sign high-half modes. Uses a valid/ready handshake with full backpressure and sustains one multiply per cycle.

---
 rtl/dnn_accel_mult_pipe.sv | 148 ++++++++++++++
 tb/tb_dnn_accel_mult_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_accel_mult_pipe.sv
// Pipelined WIDTH x WIDTH integer multiplier (limb partial products, then combine and half-select).
// Latency: 2 register stages; result valid two cycles after the accept cycle, one result per cycle.
// Backpressure: valid/ready, in_ready = stage-1 advance (combinational from out_ready), max 2 beats in flight.
// Optional feature macro: MULT_PIPE_HIGH_EN enables MULH/MULHSU/MULHU; without it every mode returns MUL.
module dnn_accel_mult_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);

  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  localparam logic [1:0] MODE_MUL    = 2'b00;
  localparam logic [1:0] MODE_MULH   = 2'b01;
  localparam logic [1:0] MODE_MULHSU = 2'b10;

  // Handshake / advance control
  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic accept;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid & in_ready;

  // Operand limbs, zero-extended to WIDTH so each H x H product fits exactly
  logic [WIDTH-1:0] a_lo;
  logic [WIDTH-1:0] a_hi;
  logic [WIDTH-1:0] b_lo;
  logic [WIDTH-1:0] b_hi;

  assign a_lo = {{H{1'b0}}, in_a[H-1:0]};
  assign a_hi = {{H{1'b0}}, in_a[WIDTH-1:H]};
  assign b_lo = {{H{1'b0}}, in_b[H-1:0]};
  assign b_hi = {{H{1'b0}}, in_b[WIDTH-1:H]};

  logic [WIDTH-1:0] pp_ll_d;
  logic [WIDTH-1:0] pp_hl_d;
  logic [WIDTH-1:0] pp_lh_d;

  assign pp_ll_d = a_lo * b_lo;
  assign pp_hl_d = a_hi * b_lo;
  assign pp_lh_d = a_lo * b_hi;

  logic [WIDTH-1:0] s1_pp_ll;
  logic [WIDTH-1:0] s1_pp_hl;
  logic [WIDTH-1:0] s1_pp_lh;

`ifdef MULT_PIPE_HIGH_EN
  // High-half support: top partial product plus two's-complement corrections.
  // Signed product = ua*ub - (a<0 ? ub<<W : 0) - (b<0 ? ua<<W : 0)  (mod 2^2W)
  logic [WIDTH-1:0] pp_hh_d;
  logic [WIDTH-1:0] corr_a_d;
  logic [WIDTH-1:0] corr_b_d;
  logic             signed_a;

  assign pp_hh_d  = a_hi * b_hi;
  assign signed_a = (in_mode == MODE_MULH) || (in_mode == MODE_MULHSU);
  assign corr_a_d = (signed_a && in_a[WIDTH-1]) ? in_b : '0;
  assign corr_b_d = ((in_mode == MODE_MULH) && in_b[WIDTH-1]) ? in_a : '0;

  logic [WIDTH-1:0] s1_pp_hh;
  logic [WIDTH-1:0] s1_corr_a;
  logic [WIDTH-1:0] s1_corr_b;
  logic [1:0]       s1_mode;
`else
  // Low-half only build: the mode field has no effect on the result
  logic unused_mode;
  assign unused_mode = ^in_mode;
`endif

  // Stage-1 occupancy: fill on accept, empty when it drains with no new beat
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= accept;
    end
  end

  // Stage-1 payload: partial products and mode captured only on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_pp_ll  <= pp_ll_d;
      s1_pp_hl  <= pp_hl_d;
      s1_pp_lh  <= pp_lh_d;
`ifdef MULT_PIPE_HIGH_EN
      s1_pp_hh  <= pp_hh_d;
      s1_corr_a <= corr_a_d;
      s1_corr_b <= corr_b_d;
      s1_mode   <= in_mode;
`endif
    end
  end

  // Combine partial products and pick the requested half
  logic [WIDTH-1:0] result_d;

`ifdef MULT_PIPE_HIGH_EN
  logic [W2-1:0]    prod_sum;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] corr_sum;

  always_comb begin
    prod_sum = {{WIDTH{1'b0}}, s1_pp_ll}
             + ({{WIDTH{1'b0}}, s1_pp_hl} << H)
             + ({{WIDTH{1'b0}}, s1_pp_lh} << H)
             + {s1_pp_hh, {WIDTH{1'b0}}};
    // Carry out of the correction sum lands at bit 2W and is dropped
    corr_sum = s1_corr_a + s1_corr_b;
    prod     = prod_sum - {corr_sum, {WIDTH{1'b0}}};
    result_d = (s1_mode == MODE_MUL) ? prod[WIDTH-1:0] : prod[W2-1:WIDTH];
  end
`else
  always_comb begin
    result_d = s1_pp_ll + (s1_pp_hl << H) + (s1_pp_lh << H);
  end
`endif

  // Stage-2 / output register: holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= result_d;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule

// File: tb/tb_dnn_accel_mult_pipe.sv
// Directed and table-driven bench for dnn_accel_mult_pipe (WIDTH 32, plus 16 and 64 sweeps).
// Expected values are hand-computed constants or a 2*WIDTH reference multiply.
// Expectations for the high-half modes follow MULT_PIPE_HIGH_EN.
module tb_dnn_accel_mult_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_result;
  logic [1:0]  in_mode;

  logic        r16_valid, r16_ready, r16_ovalid, r16_oready;
  logic [15:0] r16_a, r16_b, r16_res;
  logic [1:0]  r16_mode;

  logic        r64_valid, r64_ready, r64_ovalid, r64_oready;
  logic [63:0] r64_a, r64_b, r64_res;
  logic [1:0]  r64_mode;

  dnn_accel_mult_pipe #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  dnn_accel_mult_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(r16_valid), .in_ready(r16_ready), .in_a(r16_a), .in_b(r16_b), .in_mode(r16_mode),
    .out_valid(r16_ovalid), .out_ready(r16_oready), .out_result(r16_res)
  );

  dnn_accel_mult_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset),
    .in_valid(r64_valid), .in_ready(r64_ready), .in_a(r64_a), .in_b(r64_b), .in_mode(r64_mode),
    .out_valid(r64_ovalid), .out_ready(r64_oready), .out_result(r64_res)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: full 2w-bit product via sign/zero extension to 128 bits
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic [1:0] mode, input int w);
    logic [127:0] mask, ea, eb, p;
    mask = (128'd1 << w) - 128'd1;
    ea = {64'd0, a} & mask;
    eb = {64'd0, b} & mask;
    if ((mode == 2'b01 || mode == 2'b10) && a[w-1]) ea = ea | ~mask;
    if (mode == 2'b01 && b[w-1]) eb = eb | ~mask;
    p = ea * eb;
`ifdef MULT_PIPE_HIGH_EN
    if (mode != 2'b00) return (p >> w) & mask;
`endif
    return p & mask;
  endfunction

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  mode;
    logic [31:0] exp_full;  // all modes built
    logic [31:0] exp_low;   // low-half-only build
  } vec_t;

  vec_t vecs[11];

  // Scoreboard for streamed traffic on the 32-bit instance
  logic [31:0] exp_q[$];
  int          tick_no;

  task automatic tick(output bit acc, output bit pop);
    logic [31:0] res, exp;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready;
    res = out_result;
    exp = ref_mul({32'd0, in_a}, {32'd0, in_b}, in_mode, 32);
    @(posedge clk);
    if (pop) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=0x%0h required=none", res);
      end else begin
        check("stream_order", res, exp_q.pop_front());
      end
    end
    if (acc) exp_q.push_back(exp);
    #1;
    tick_no++;
  endtask

  initial begin
    bit acc, pop;
    int first_pop, last_pop, pops, accs, k;
    logic [31:0] held;
    bit held_set;

    vecs[0]  = '{"mul_small",     32'h0001_0003, 32'h0002_0005, 2'b00, 32'h000B_000F, 32'h000B_000F};
    vecs[1]  = '{"mul_ones",      32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 32'h0000_0001};
    vecs[2]  = '{"mulhu_ones",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3]  = '{"mulh_ones",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000, 32'h0000_0001};
    vecs[4]  = '{"mulhsu_ones",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF, 32'h0000_0001};
    vecs[5]  = '{"mulh_min",      32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 32'h0000_0000};
    vecs[6]  = '{"mulhsu_min",    32'h8000_0000, 32'h8000_0000, 2'b10, 32'hC000_0000, 32'h0000_0000};
    vecs[7]  = '{"mul_ffff_sq",   32'h0000_FFFF, 32'h0000_FFFF, 2'b00, 32'hFFFE_0001, 32'hFFFE_0001};
    vecs[8]  = '{"mulh_m2x3",     32'hFFFF_FFFE, 32'h0000_0003, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[9]  = '{"mulhu_m2x3",    32'hFFFF_FFFE, 32'h0000_0003, 2'b11, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[10] = '{"mulhsu_3xm2",   32'h0000_0003, 32'hFFFF_FFFE, 2'b10, 32'h0000_0002, 32'hFFFF_FFFA};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0; in_mode = '0;
    r16_valid = 1'b0; r16_oready = 1'b1; r16_a = '0; r16_b = '0; r16_mode = '0;
    r64_valid = 1'b0; r64_oready = 1'b1; r64_a = '0; r64_b = '0; r64_mode = '0;
    tick_no = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_in_ready", in_ready, 1'b1);

    // Directed table, one beat at a time
    for (int i = 0; i < 11; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_mode = vecs[i].mode; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int t = 0; t < 4 && !out_valid; t++) begin
        @(posedge clk); #1;
      end
      check({vecs[i].name, "_valid"}, out_valid, 1'b1);
`ifdef MULT_PIPE_HIGH_EN
      check(vecs[i].name, out_result, vecs[i].exp_full);
`else
      check(vecs[i].name, out_result, vecs[i].exp_low);
`endif
      @(posedge clk); #1;
    end

    // Back-to-back stream of 8 beats, consumer always ready
    out_ready = 1'b1; first_pop = -1; last_pop = -1; pops = 0; tick_no = 0;
    for (int c = 0; c < 14; c++) begin
      in_valid = (c < 8);
      in_a     = 32'h1357_0001 * (c + 1);
      in_b     = 32'hF00D_0000 ^ c;
      in_mode  = c[1:0];
      tick(acc, pop);
      if (pop) begin
        if (first_pop < 0) first_pop = c;
        last_pop = c;
        pops++;
      end
    end
    check("stream_first_latency", first_pop, 2);
    check("stream_count", pops, 8);
    check("stream_back_to_back", last_pop - first_pop, 7);
    check("stream_drained", exp_q.size(), 0);

    // Backpressure: consumer stalls for 5 cycles with input offered throughout
    out_ready = 1'b0; in_valid = 1'b1; k = 0; accs = 0; held_set = 1'b0; pops = 0;
    for (int c = 0; c < 5; c++) begin
      in_a = 32'hA000_0003 + k; in_b = 32'h0000_0101 * (k + 1); in_mode = k[1:0];
      if (out_valid) begin
        if (!held_set) begin
          held = out_result;
          held_set = 1'b1;
        end else begin
          check("stall_result_stable", out_result, held);
        end
      end
      tick(acc, pop);
      if (acc) begin accs++; k++; end
    end
    check("stall_accepts", accs, 2);
    check("stall_in_ready_low", in_ready, 1'b0);
    check("stall_out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    check("stall_release_in_ready", in_ready, 1'b1);
    for (int c = 0; c < 20 && (k < 6 || exp_q.size() != 0); c++) begin
      in_valid = (k < 6);
      in_a = 32'hA000_0003 + k; in_b = 32'h0000_0101 * (k + 1); in_mode = k[1:0];
      tick(acc, pop);
      if (acc) k++;
      if (pop) pops++;
    end
    in_valid = 1'b0;
    check("bp_total_accepts", k, 6);
    check("bp_total_results", pops, 6);
    check("bp_drained", exp_q.size(), 0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; in_a = 32'h0BAD_0000 + c; in_b = 32'h0000_0007; in_mode = 2'b00;
      tick(acc, pop);
    end
    in_valid = 1'b0;
    check("full_in_ready_low", in_ready, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_in_ready", in_ready, 1'b1);
    check("midreset_out_result", out_result, 32'd0);
    out_ready = 1'b1; pops = 0;
    for (int c = 0; c < 5; c++) begin
      tick(acc, pop);
      if (pop) pops++;
    end
    check("midreset_no_stale", pops, 0);

    // Random sweeps on the 16- and 64-bit instances
    for (int i = 0; i < 16; i++) begin
      r16_a = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h8000 : 16'($urandom);
      r16_b = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h8000 : 16'($urandom);
      r16_mode = 2'($urandom_range(0, 3));
      r16_valid = 1'b1;
      @(posedge clk); #1;
      r16_valid = 1'b0;
      for (int t = 0; t < 4 && !r16_ovalid; t++) begin
        @(posedge clk); #1;
      end
      check("w16_valid", r16_ovalid, 1'b1);
      check("w16_result", r16_res, ref_mul({48'd0, r16_a}, {48'd0, r16_b}, r16_mode, 16));
    end
    for (int i = 0; i < 16; i++) begin
      r64_a = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (i == 1) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      r64_b = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : (i == 1) ? 64'h8000_0000_0000_0000 : {$urandom, $urandom};
      r64_mode = 2'($urandom_range(0, 3));
      r64_valid = 1'b1;
      @(posedge clk); #1;
      r64_valid = 1'b0;
      for (int t = 0; t < 4 && !r64_ovalid; t++) begin
        @(posedge clk); #1;
      end
      check("w64_valid", r64_ovalid, 1'b1);
      check("w64_result", r64_res, ref_mul(r64_a, r64_b, r64_mode, 64));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
